id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage for the MIPS multicycle pipelined core. It takes decoded instructions from fetch/decode and drives the two read addresses of the register file. It captures the returned operands with write-port bypass and presents them to execute through a valid/ready handshake. A two-entry skid buffer keeps `in_ready` purely registered, and held operands snoop register-file writes so a stalled instruction never carries stale data.

## Interface
- `DW`, 32, data/operand width
- `AW`, 5, register address width

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept (registered)
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction PC
- `rf_rd_addr1`  out  AW  `in_instr[25:21]` (rs), combinational
- `rf_rd_addr2`  out  AW  `in_instr[20:16]` (rt), combinational
- `rf_rd_data1`, `rf_rd_data2`  in  DW  register file read data (combinational read)
- `wb_en`, `wb_addr[AW]`, `wb_data[DW]`  in  copy of the register-file write port
- `flush`  in  1  synchronous kill of all held entries
- `out_valid`  out  1  entry presented to execute
- `out_ready`  in  1  execute accepts
- `out_instr[32]`, `out_pc[32]`, `out_rs[AW]`, `out_rt[AW]`, `out_op_a[DW]`, `out_op_b[DW]`  out  held entry fields

## Operation
- Entry = {instr, pc, rs, rt, op_a, op_b}. There are two storage slots: MAIN drives the outputs, and SKID holds an overflow entry.
- Accept: `in_valid && in_ready`. Fire: `out_valid && out_ready`.
- Capture bypass: when `wb_en && wb_addr==rs`, op_a = `wb_data`; otherwise op_a = `rf_rd_data1`. op_b uses the same rule with rt. There is no special case for register 0, because the register file stores r0 like any other register.
- Snoop: every cycle, for each valid slot, `wb_en && wb_addr==slot.rs` sets `slot.op_a <= wb_data`. The same rule applies to op_b with rt.
- When SKID moves into MAIN in the same cycle as a matching write, MAIN receives the snooped value.
- FSM states and outputs:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: MAIN valid, in_ready=1.
  - TWO: both valid, in_ready=0.
- FSM transitions:
  - EMPTY: accept -> ONE (load MAIN).
  - ONE: accept & fire -> ONE (MAIN reloaded). Accept & !fire -> TWO (load SKID). !accept & fire -> EMPTY. Otherwise hold.
  - TWO: fire -> ONE (SKID -> MAIN). Otherwise hold. Accept cannot occur in TWO.
- Flush has priority over everything: next state is EMPTY and any same-cycle accepted input is dropped. Data registers may keep their values, but out_valid must be 0.
- Ordering is strictly FIFO. No entry is duplicated or lost except through flush.

## Timing
- Reset (asserted low, asynchronous): state EMPTY, `out_valid`=0, `in_ready`=1, all `out_*` data = 0. Deassertion is synchronised externally.
- Latency: an input accepted at edge N appears on `out_*` after edge N (one cycle).
- Throughput: one entry per cycle when `out_ready` is held high.
- `in_ready` depends only on flops (`!skid_valid`). It never depends combinationally on `out_ready`.
- `out_*` are held stable while `out_valid && !out_ready`, except for snoop updates to op_a/op_b.
- `rf_rd_addr*` follow `in_instr` every cycle, whether or not `in_valid` is high.
- Reset mid-operation: both slots are discarded immediately.

## Test plan
- Reset then a single instruction:
  - Stimulus: `in_instr`=0x01095020 (rs=8, rt=9), rf data 0xA/0xB, out_ready=1.
  - Required: next cycle out_valid=1, op_a=0xA, op_b=0xB, rs=8, rt=9. The following cycle out_valid=0.
- Capture bypass:
  - Stimulus: accept rs=8 while wb_en=1, wb_addr=8, wb_data=0x1234, rf_rd_data1=0xA.
  - Required: op_a=0x1234.
- Stall with snoop:
  - Stimulus: out_ready=0, MAIN rt=9. Write wb_addr=9, data 0xBEEF.
  - Required: op_b becomes 0xBEEF the next cycle. All other fields remain unchanged.
- Backpressure FIFO:
  - Stimulus: out_ready=0, stream PCs 0x0, 0x4, 0x8.
  - Required: in_ready drops after the second accept. The third entry is held upstream. Releasing out_ready yields 0x0, 0x4, 0x8 in order with no gaps.
- Flush:
  - Stimulus: state TWO, then flush=1 with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- Async reset mid-stream:
  - Stimulus: drive reset low between edges while in TWO.
  - Required: out_valid=0, in_ready=1, and out data=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/execute stage bus: upstream, register file, writeback snoop, downstream
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic [31:0]   in_pc;
   logic [AW-1:0] rf_rd_addr1;
   logic [AW-1:0] rf_rd_addr2;
   logic [DW-1:0] rf_rd_data1;
   logic [DW-1:0] rf_rd_data2;
   logic          wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
   logic [AW-1:0] out_rs;
   logic [AW-1:0] out_rt;
   logic [DW-1:0] out_op_a;
   logic [DW-1:0] out_op_b;

   modport slave (
      input  in_valid, in_instr, in_pc, rf_rd_data1, rf_rd_data2,
             wb_en, wb_addr, wb_data, flush, out_ready,
      output in_ready, rf_rd_addr1, rf_rd_addr2, out_valid,
             out_instr, out_pc, out_rs, out_rt, out_op_a, out_op_b
   );

   modport master (
      output in_valid, in_instr, in_pc, rf_rd_data1, rf_rd_data2,
             wb_en, wb_addr, wb_data, flush, out_ready,
      input  in_ready, rf_rd_addr1, rf_rd_addr2, out_valid,
             out_instr, out_pc, out_rs, out_rt, out_op_a, out_op_b
   );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute stage with operand bypass, writeback snoop and 2-entry skid buffer
module id_ex_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic          w_load_main_in;
   logic          w_load_main_skid;
   logic          w_load_skid;

   logic [31:0]   r_main_instr, r_main_pc, r_skid_instr, r_skid_pc;
   logic [AW-1:0] r_main_rs, r_main_rt, r_skid_rs, r_skid_rt;
   logic [DW-1:0] r_main_a, r_main_b, r_skid_a, r_skid_b;

   logic [AW-1:0] w_rs, w_rt;
   logic [DW-1:0] w_cap_a, w_cap_b;
   logic [DW-1:0] w_main_a_snp, w_main_b_snp, w_skid_a_snp, w_skid_b_snp;
   logic          w_accept, w_fire;

   assign w_rs = bus.in_instr[21 +: AW];
   assign w_rt = bus.in_instr[16 +: AW];
   assign bus.rf_rd_addr1 = w_rs;
   assign bus.rf_rd_addr2 = w_rt;

   // A same-cycle write is newer than what the register file returns.
   assign w_cap_a = (bus.wb_en && bus.wb_addr == w_rs) ? bus.wb_data : bus.rf_rd_data1;
   assign w_cap_b = (bus.wb_en && bus.wb_addr == w_rt) ? bus.wb_data : bus.rf_rd_data2;

   assign w_main_a_snp = (bus.wb_en && bus.wb_addr == r_main_rs) ? bus.wb_data : r_main_a;
   assign w_main_b_snp = (bus.wb_en && bus.wb_addr == r_main_rt) ? bus.wb_data : r_main_b;
   assign w_skid_a_snp = (bus.wb_en && bus.wb_addr == r_skid_rs) ? bus.wb_data : r_skid_a;
   assign w_skid_b_snp = (bus.wb_en && bus.wb_addr == r_skid_rt) ? bus.wb_data : r_skid_b;

   assign bus.in_ready  = (r_state != S_TWO);
   assign bus.out_valid = (r_state != S_EMPTY);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_fire        = bus.out_valid && bus.out_ready;

   assign bus.out_instr = r_main_instr;
   assign bus.out_pc    = r_main_pc;
   assign bus.out_rs    = r_main_rs;
   assign bus.out_rt    = r_main_rt;
   assign bus.out_op_a  = r_main_a;
   assign bus.out_op_b  = r_main_b;

   always_comb begin
      w_next_state     = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (bus.flush) begin
         w_next_state = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_next_state   = S_ONE;
                  w_load_main_in = 1'b1;
               end
            end
            S_ONE: begin
               if (w_accept && w_fire) begin
                  w_load_main_in = 1'b1;
               end else if (w_accept) begin
                  w_next_state = S_TWO;
                  w_load_skid  = 1'b1;
               end else if (w_fire) begin
                  w_next_state = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_fire) begin
                  w_next_state     = S_ONE;
                  w_load_main_skid = 1'b1;
               end
            end
            default: w_next_state = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_EMPTY;
         r_main_instr <= '0;
         r_main_pc    <= '0;
         r_main_rs    <= '0;
         r_main_rt    <= '0;
         r_main_a     <= '0;
         r_main_b     <= '0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_rs    <= '0;
         r_skid_rt    <= '0;
         r_skid_a     <= '0;
         r_skid_b     <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_load_main_in) begin
            r_main_instr <= bus.in_instr;
            r_main_pc    <= bus.in_pc;
            r_main_rs    <= w_rs;
            r_main_rt    <= w_rt;
            r_main_a     <= w_cap_a;
            r_main_b     <= w_cap_b;
         end else if (w_load_main_skid) begin
            // Promoted entry carries any write landing this same cycle.
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_rs    <= r_skid_rs;
            r_main_rt    <= r_skid_rt;
            r_main_a     <= w_skid_a_snp;
            r_main_b     <= w_skid_b_snp;
         end else begin
            r_main_a     <= w_main_a_snp;
            r_main_b     <= w_main_b_snp;
         end

         if (w_load_skid) begin
            r_skid_instr <= bus.in_instr;
            r_skid_pc    <= bus.in_pc;
            r_skid_rs    <= w_rs;
            r_skid_rt    <= w_rt;
            r_skid_a     <= w_cap_a;
            r_skid_b     <= w_cap_b;
         end else begin
            r_skid_a     <= w_skid_a_snp;
            r_skid_b     <= w_skid_b_snp;
         end
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized bench for id_ex_stage against a queue-based reference model
module tb_id_ex_stage;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   bit   check_en;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] a;
      logic [31:0] b;
   } ent_t;

   ent_t        q[$];
   logic [31:0] rf [32];

   id_ex_stage_if #(.DW(32), .AW(5)) bus ();

   id_ex_stage #(.DW(32), .AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.rf_rd_data1 = rf[bus.rf_rd_addr1];
   assign bus.rf_rd_data2 = rf[bus.rf_rd_addr2];

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
         rf[8] <= 32'hA;
         rf[9] <= 32'hB;
      end else if (bus.wb_en) begin
         rf[bus.wb_addr] <= bus.wb_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two entries whose operands track later writes.
   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
      end else begin
         automatic bit acc  = bus.in_valid && (q.size() < 2);
         automatic bit fire = (q.size() > 0) && bus.out_ready;
         automatic ent_t e;
         if (bus.flush) begin
            q.delete();
         end else begin
            if (fire) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
               if (bus.wb_en && bus.wb_addr == q[i].rs) q[i].a = bus.wb_data;
               if (bus.wb_en && bus.wb_addr == q[i].rt) q[i].b = bus.wb_data;
            end
            if (acc) begin
               e.instr = bus.in_instr;
               e.pc    = bus.in_pc;
               e.rs    = bus.in_instr[25:21];
               e.rt    = bus.in_instr[20:16];
               e.a     = (bus.wb_en && bus.wb_addr == e.rs) ? bus.wb_data : rf[e.rs];
               e.b     = (bus.wb_en && bus.wb_addr == e.rt) ? bus.wb_data : rf[e.rt];
               q.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en && reset) begin
         chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
         chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
         chk("rf_rd_addr1", {27'b0, bus.rf_rd_addr1}, {27'b0, bus.in_instr[25:21]});
         chk("rf_rd_addr2", {27'b0, bus.rf_rd_addr2}, {27'b0, bus.in_instr[20:16]});
         if (q.size() != 0) begin
            chk("out_instr", bus.out_instr, q[0].instr);
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_rs", {27'b0, bus.out_rs}, {27'b0, q[0].rs});
            chk("out_rt", {27'b0, bus.out_rt}, {27'b0, q[0].rt});
            chk("out_op_a", bus.out_op_a, q[0].a);
            chk("out_op_b", bus.out_op_b, q[0].b);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      check_en = 1'b0;
      reset = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = 5'd0;
      bus.wb_data   = 32'h0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_out_pc", bus.out_pc, 32'h0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_op_a", bus.out_op_a, 32'h0);
      reset = 1'b1;
      check_en = 1'b1;

      // Single instruction
      bus.out_ready = 1'b1;
      push(32'h01095020, 32'h100);
      chk("t1_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("t1_op_a", bus.out_op_a, 32'hA);
      chk("t1_op_b", bus.out_op_b, 32'hB);
      chk("t1_rs", {27'b0, bus.out_rs}, 32'd8);
      chk("t1_rt", {27'b0, bus.out_rt}, 32'd9);
      step();
      chk("t1_drain", {31'b0, bus.out_valid}, 32'd0);

      // Capture bypass
      bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h1234;
      push(32'h01095020, 32'h104);
      bus.wb_en = 1'b0;
      chk("t2_bypass", bus.out_op_a, 32'h1234);
      step();

      // Stall with snoop
      bus.out_ready = 1'b0;
      push(32'h01095020, 32'h200);
      bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hBEEF;
      step();
      bus.wb_en = 1'b0;
      chk("t3_op_b", bus.out_op_b, 32'hBEEF);
      chk("t3_op_a", bus.out_op_a, 32'h1234);
      chk("t3_pc", bus.out_pc, 32'h200);
      chk("t3_instr", bus.out_instr, 32'h01095020);
      bus.out_ready = 1'b1;
      step();

      // Backpressure ordering
      bus.out_ready = 1'b0;
      push(32'h00221820, 32'h0);
      chk("t4_rdy1", {31'b0, bus.in_ready}, 32'd1);
      push(32'h00221820, 32'h4);
      chk("t4_rdy2", {31'b0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b1; bus.in_pc = 32'h8;
      step();
      chk("t4_hold", bus.out_pc, 32'h0);
      bus.out_ready = 1'b1;
      step();
      chk("t4_pc4", bus.out_pc, 32'h4);
      chk("t4_rdy3", {31'b0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk("t4_pc8", bus.out_pc, 32'h8);
      chk("t4_v8", {31'b0, bus.out_valid}, 32'd1);
      step();
      chk("t4_empty", {31'b0, bus.out_valid}, 32'd0);

      // Flush from TWO and from ONE with a same-cycle accept
      bus.out_ready = 1'b0;
      push(32'h00221820, 32'h10);
      push(32'h00221820, 32'h14);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h18;
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("t5_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("t5_ready", {31'b0, bus.in_ready}, 32'd1);
      push(32'h00221820, 32'h30);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h34;
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (3) begin
         chk("t5_gone", {31'b0, bus.out_valid}, 32'd0);
         step();
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_instr  = {6'h0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         bus.in_pc     = $urandom;
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.wb_en     = ($urandom_range(0, 1) != 0);
         bus.wb_addr   = 5'($urandom_range(0, 7));
         bus.wb_data   = $urandom;
         bus.flush     = ($urandom_range(0, 40) == 0);
         step();
      end
      bus.wb_en = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;

      // Asynchronous reset while holding two entries
      bus.out_ready = 1'b0;
      push(32'h01095020, 32'h40);
      push(32'h01095020, 32'h44);
      chk("t6_two", {31'b0, bus.in_ready}, 32'd0);
      check_en = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("t6_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("t6_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("t6_pc", bus.out_pc, 32'h0);
      chk("t6_op_a", bus.out_op_a, 32'h0);
      chk("t6_op_b", bus.out_op_b, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
